dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Data-memory responder serving the MEM stage's load/store requests over a valid/ready request
//  channel plus a one-cycle response pulse. Word-addressed RAM; fixed, parameterised access
//  latency; one outstanding transaction. Sits between the MEM stage (initiator) and the DM
//  storage, replacing the zero-latency DM so multi-cycle memory can be modelled and stalled on.
// PARAMETERS
//  DEPTH      1024          number of 32-bit words; power of two
//  LATENCY    1             cycles from request acceptance edge to response cycle; legal 1..15
//  BASE_ADDR  32'h0000_0000 byte address of word 0
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept; transfer on edge where req_valid && req_ready
//  req_we     in   1   1 = store word (sw), 0 = load word (lw)
//  req_addr   in   32  byte address (ALU result)
//  req_wdata  in   32  store data
//  req_pc     in   32  PC of requesting instruction
//  rsp_valid  out  1   one-cycle pulse: transaction complete
//  rsp_rdata  out  32  load data; 0 for stores and out-of-range loads
//  rsp_pc     out  32  PC echoed from accepted request
// BEHAVIOUR
//  - Reset (sync, wins over everything): state=IDLE, req_ready=1, rsp_valid=0,
//    rsp_rdata=0, rsp_pc=32'h0000_3000, wait counter=0, all DEPTH words cleared to 0.
//  - Index = (req_addr - BASE_ADDR) >> 2; bits [1:0] ignored (misaligned rounds down).
//    Out of range when req_addr < BASE_ADDR or index >= DEPTH: store dropped, load returns 0.
//  - Accept at edge T latches we/addr/wdata/pc. The access commits at edge T+LATENCY-1:
//    store written, load data sampled from RAM at that edge. rsp_valid is high in cycle
//    T+LATENCY (between edges T+LATENCY-1 and T+LATENCY), exactly one cycle.
//  - FSM: IDLE -accept-> (LATENCY==1 ? RESP : WAIT, cnt=LATENCY-2).
//    WAIT: cnt!=0 -> cnt-1; cnt==0 -> commit, RESP.
//    RESP: rsp_valid=1; accept -> as from IDLE; else -> IDLE.
//  - req_ready = (state==IDLE) || (state==RESP); low throughout WAIT. With LATENCY=1
//    throughput is one request per cycle; in general one per LATENCY cycles.
//  - Accept in RESP cycle: new request sees all effects of the responding one
//    (store-then-load to same word returns new data).
//  - rsp_rdata/rsp_pc hold their last value when rsp_valid=0; consumers sample only on pulse.
//  - Reset mid-transaction (WAIT or commit edge): transaction discarded, no write
//    committed, no rsp_valid pulse.
//  - req_valid with req_ready=0 is ignored; initiator must hold request until accepted.
// CONFIGURATION
//  DM_WRITE_LOG_EN defined: at each in-range store commit edge, $display
//    "%d@%h: *%h <= %h" with $time, rsp_pc source PC, word-aligned byte address, wdata.
//    Out-of-range stores print nothing.
//  DM_WRITE_LOG_EN undefined: no $display; otherwise identical cycle behaviour.
// TESTING
//  1 Reset, LATENCY=1: load 0x0000_0010 -> rsp_valid next cycle, rsp_rdata=0, rsp_pc=req_pc.
//  2 LATENCY=3: store 0x0000_0004 <= 0x1234_5678 accepted edge T -> req_ready=0 cycles
//    T..T+1, rsp_valid only in cycle T+3; load 0x4 -> 0x1234_5678.
//  3 LATENCY=1 back-to-back: store 0x8 <= 0xDEAD_BEEF then load 0x8 on next cycle
//    -> two consecutive rsp_valid pulses, second with rdata=0xDEAD_BEEF.
//  4 DEPTH=1024: store 0x0000_1000 <= 0xFFFF_FFFF -> rsp_valid, no log line; load 0x1000
//    -> 0; load 0x0 -> 0 (no aliasing).
//  5 Misaligned store 0x0000_0007 <= 0x0000_00A5 -> load 0x4 returns 0x0000_00A5.
//  6 LATENCY=4: store 0xC <= 0x55AA_55AA, reset during WAIT -> no rsp_valid, req_ready=1
//    after reset, load 0xC -> 0.

Source files
------------

// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------------------------
// dm_responder -- data-memory responder for the MEM stage.
//
// Serves word load/store requests over a valid/ready request channel and answers each one with
// a single-cycle rsp_valid pulse after a fixed LATENCY. Word-addressed RAM with one outstanding
// transaction.
//
// Parameters:
//   DEPTH      number of 32-bit words (power of two, >= 2)
//   LATENCY    cycles from request acceptance edge to response cycle (1..15)
//   BASE_ADDR  byte address of word 0
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (also clears the RAM)
//   req_valid  request present
//   req_ready  responder can accept (transfer on edge where req_valid && req_ready)
//   req_we     1 = store word, 0 = load word
//   req_addr   byte address
//   req_wdata  store data
//   req_pc     PC of requesting instruction
//   rsp_valid  one-cycle pulse: transaction complete
//   rsp_rdata  load data; 0 for stores and out-of-range loads; held between pulses
//   rsp_pc     PC echoed from the accepted request; held between pulses
//
// Optional feature macro: DM_WRITE_LOG_EN
//   When defined, every in-range store commit prints "<time>@<pc>: *<addr> <= <data>".
// ---------------------------------------------------------------------------------------------
module dm_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [31:0] rsp_pc
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    // Request latched at the acceptance edge, used when the commit happens later.
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] lat_pc;

    logic [31:0] mem [DEPTH];

    // Commit-side view: with LATENCY==1 the access commits on the acceptance edge itself and so
    // uses the live request; otherwise it uses the latched copy on the last WAIT edge.
    logic        accept;
    logic        commit_now;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] c_pc;
    logic [31:0] c_off;
    logic [31:0] c_word;
    logic        c_in_range;
    logic [IDX_W-1:0] c_idx;

    assign req_ready = (state == StIdle) || (state == StResp);
    assign accept    = req_valid && req_ready;

    always_comb begin
        commit_now = 1'b0;
        c_we       = lat_we;
        c_addr     = lat_addr;
        c_wdata    = lat_wdata;
        c_pc       = lat_pc;
        if (LATENCY == 1) begin
            commit_now = accept;
            c_we       = req_we;
            c_addr     = req_addr;
            c_wdata    = req_wdata;
            c_pc       = req_pc;
        end else begin
            commit_now = (state == StWait) && (cnt == 4'd0);
        end
    end

    assign c_off      = c_addr - BASE_ADDR;
    assign c_word     = {2'b00, c_off[31:2]};
    assign c_in_range = (c_addr >= BASE_ADDR) && (c_word < DEPTH_W);
    assign c_idx      = c_off[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_pc    <= 32'h0000_3000;
            lat_we    <= 1'b0;
            lat_addr  <= 32'h0000_0000;
            lat_wdata <= 32'h0000_0000;
            lat_pc    <= 32'h0000_0000;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 32'h0000_0000;
            end
        end else begin
            rsp_valid <= 1'b0;

            unique case (state)
                StIdle, StResp: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_pc    <= req_pc;
                        if (LATENCY == 1) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= StWait;
                            cnt   <= 4'(LATENCY - 2);
                        end
                    end else begin
                        state <= StIdle;
                    end
                end
                StWait: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase

            if (commit_now) begin
                if (c_we && c_in_range) begin
                    mem[c_idx] <= c_wdata;
                end
                // Load data is the RAM content seen at the commit edge.
                rsp_rdata <= (!c_we && c_in_range) ? mem[c_idx] : 32'h0000_0000;
                rsp_pc    <= c_pc;
`ifdef DM_WRITE_LOG_EN
                if (c_we && c_in_range) begin
                    $display("%d@%h: *%h <= %h", $time, c_pc, {c_addr[31:2], 2'b00}, c_wdata);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    logic        clk;
    logic [2:0]  reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_we;
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [31:0] req_pc    [3];
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_rdata [3];
    logic [31:0] rsp_pc    [3];

    int errors = 0;
    int checks = 0;

    // Three instances: index 0 LATENCY=1, index 1 LATENCY=3, index 2 LATENCY=4.
    dm_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut_l1 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_pc(req_pc[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_pc(rsp_pc[0])
    );

    dm_responder #(.DEPTH(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u_dut_l3 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_pc(req_pc[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_pc(rsp_pc[1])
    );

    dm_responder #(.DEPTH(1024), .LATENCY(4), .BASE_ADDR(32'h0)) u_dut_l4 (
        .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_pc(req_pc[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_pc(rsp_pc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request on instance d and wait for its response. lat counts negedges from the
    // accept edge to the first negedge with rsp_valid high; ready_lo counts negedges in between
    // with req_ready low. lat >= 40 means no response arrived.
    task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc,
                          output int lat, output int ready_lo,
                          output logic [31:0] rdata, output logic [31:0] rpc);
        int guard;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_pc[d]    = pc;
        guard = 0;
        while (!req_ready[d] && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat      = 1;
        ready_lo = 0;
        while (!rsp_valid[d] && lat < 40) begin
            if (!req_ready[d]) ready_lo++;
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata[d];
        rpc   = rsp_pc[d];
    endtask

    task automatic pulse_reset(input int d);
        @(negedge clk);
        reset[d] = 1'b1;
        @(negedge clk);
        reset[d] = 1'b0;
    endtask

    task automatic test_reset();
        int lat, rl;
        logic [31:0] rd, rp;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hs[%0d]: ready=%b valid=%b, required ready=1 valid=0",
                         d, req_ready[d], rsp_valid[d]);
            end
            checks++;
            if (rsp_rdata[d] !== 32'h0 || rsp_pc[d] !== 32'h0000_3000) begin
                errors++;
                $display("FAIL reset_data[%0d]: rdata=%h pc=%h, required 00000000/00003000",
                         d, rsp_rdata[d], rsp_pc[d]);
            end
        end
        do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0100, lat, rl, rd, rp);
        checks++;
        if (lat !== 1 || rd !== 32'h0 || rp !== 32'h0000_0100) begin
            errors++;
            $display("FAIL reset_load: lat=%0d rdata=%h pc=%h, required 1/00000000/00000100",
                     lat, rd, rp);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_pulse: rsp_valid=%b one cycle later, required 0",
                     rsp_valid[0]);
        end
    endtask

    task automatic test_latency3();
        int lat, rl;
        logic [31:0] rd, rp;
        do_txn(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0000_0200, lat, rl, rd, rp);
        checks++;
        if (lat !== 3 || rl !== 2) begin
            errors++;
            $display("FAIL l3_store_timing: lat=%0d ready_low=%0d, required 3/2", lat, rl);
        end
        checks++;
        if (rd !== 32'h0 || rp !== 32'h0000_0200 || req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL l3_store_rsp: rdata=%h pc=%h ready=%b, required 0/00000200/1",
                     rd, rp, req_ready[1]);
        end
        do_txn(1, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0204, lat, rl, rd, rp);
        checks++;
        if (lat !== 3 || rd !== 32'h1234_5678 || rp !== 32'h0000_0204) begin
            errors++;
            $display("FAIL l3_load: lat=%0d rdata=%h pc=%h, required 3/12345678/00000204",
                     lat, rd, rp);
        end
        // Outputs hold between pulses.
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h1234_5678 ||
            rsp_pc[1] !== 32'h0000_0204) begin
            errors++;
            $display("FAIL l3_hold: valid=%b rdata=%h pc=%h, required 0/12345678/00000204",
                     rsp_valid[1], rsp_rdata[1], rsp_pc[1]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h0000_0008;
        req_wdata[0] = 32'hDEAD_BEEF;
        req_pc[0]    = 32'h0000_0300;
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b1 || rsp_pc[0] !== 32'h0000_0300) begin
            errors++;
            $display("FAIL b2b_first: valid=%b ready=%b pc=%h, required 1/1/00000300",
                     rsp_valid[0], req_ready[0], rsp_pc[0]);
        end
        req_we[0]    = 1'b0;
        req_wdata[0] = 32'h0;
        req_pc[0]    = 32'h0000_0304;
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEAD_BEEF ||
            rsp_pc[0] !== 32'h0000_0304) begin
            errors++;
            $display("FAIL b2b_second: valid=%b rdata=%h pc=%h, required 1/deadbeef/00000304",
                     rsp_valid[0], rsp_rdata[0], rsp_pc[0]);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: rsp_valid=%b, required 0", rsp_valid[0]);
        end
    endtask

    task automatic test_out_of_range();
        int lat, rl;
        logic [31:0] rd, rp;
        do_txn(0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0400, lat, rl, rd, rp);
        checks++;
        if (lat !== 1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_store: lat=%0d rdata=%h, required 1/00000000", lat, rd);
        end
        do_txn(0, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_0404, lat, rl, rd, rp);
        checks++;
        if (lat !== 1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_load: lat=%0d rdata=%h, required 1/00000000", lat, rd);
        end
        do_txn(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0408, lat, rl, rd, rp);
        checks++;
        if (lat !== 1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_alias: lat=%0d rdata=%h, required 1/00000000", lat, rd);
        end
    endtask

    task automatic test_misaligned();
        int lat, rl;
        logic [31:0] rd, rp;
        do_txn(0, 1'b1, 32'h0000_0007, 32'h0000_00A5, 32'h0000_0500, lat, rl, rd, rp);
        do_txn(0, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0504, lat, rl, rd, rp);
        checks++;
        if (lat !== 1 || rd !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL misaligned: lat=%0d rdata=%h, required 1/000000a5", lat, rd);
        end
        // Neighbouring word untouched by the misaligned store.
        do_txn(0, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_0508, lat, rl, rd, rp);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL misaligned_neighbour: rdata=%h, required deadbeef", rd);
        end
    endtask

    task automatic test_reset_mid_txn();
        int lat, rl;
        int seen;
        logic [31:0] rd, rp;
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h0000_000C;
        req_wdata[2] = 32'h55AA_55AA;
        req_pc[2]    = 32'h0000_0600;
        @(negedge clk);
        req_valid[2] = 1'b0;
        checks++;
        if (req_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL l4_wait_ready: req_ready=%b, required 0", req_ready[2]);
        end
        @(negedge clk);
        reset[2] = 1'b1;
        @(negedge clk);
        reset[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid[2]) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0 || req_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL l4_reset_abort: pulses=%0d ready=%b, required 0/1",
                     seen, req_ready[2]);
        end
        do_txn(2, 1'b0, 32'h0000_000C, 32'h0, 32'h0000_0604, lat, rl, rd, rp);
        checks++;
        if (lat !== 4 || rl !== 3 || rd !== 32'h0) begin
            errors++;
            $display("FAIL l4_load_after_reset: lat=%0d ready_low=%0d rdata=%h, required 4/3/0",
                     lat, rl, rd);
        end
    endtask

    initial begin
        reset     = 3'b111;
        req_valid = 3'b000;
        req_we    = 3'b000;
        for (int d = 0; d < 3; d++) begin
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
            req_pc[d]    = 32'h0;
        end
        repeat (2) @(negedge clk);
        reset = 3'b000;
        @(negedge clk);

        test_reset();
        test_latency3();
        test_back_to_back();
        test_out_of_range();
        test_misaligned();
        test_reset_mid_txn();
        pulse_reset(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
